// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        CPU = 1'b0,
        DMA = 1'b1
    } master_e;

    // Wait counter must hold WAIT_STATES and never collapse to zero bits.
    function automatic int cnt_width(input int ws);
        return (ws > 0) ? $clog2(ws + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin pick with registered last grant
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_cpu,
    input  logic    req_dma,
    input  logic    take,
    output master_e pick,
    output logic    any_req
);

    master_e last_grant_q;
    master_e last_grant_d;

    // On a tie the master that did not win last time is picked.
    always_comb begin
        any_req = req_cpu | req_dma;
        if (req_cpu && req_dma) begin
            pick = (last_grant_q == DMA) ? CPU : DMA;
        end else if (req_cpu) begin
            pick = CPU;
        end else begin
            pick = DMA;
        end
    end

    // Remember the winner whenever the bus is actually handed out.
    always_comb begin
        last_grant_d = last_grant_q;
        if (take && any_req) begin
            last_grant_d = pick;
        end
    end

    // Reset to DMA so the CPU wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= DMA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with wait states
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant
);

    localparam int              CNT_W    = cnt_width(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

    arb_state_e        state_q,     state_d;
    master_e           owner_q,     owner_d;
    logic              wr_q,        wr_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    master_e pick;
    logic    any_req;
    logic    take;

    assign take = (state_q == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req_cpu (cpu_req),
        .req_dma (dma_req),
        .take    (take),
        .pick    (pick),
        .any_req (any_req)
    );

    // Sequencer: latch the winner's request, count wait states, capture read data.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick;
                    if (pick == CPU) begin
                        wr_d    = cpu_wr;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        wr_d    = dma_wr;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!wr_q) begin
                        if (owner_q == CPU) begin
                            cpu_rdata_d = mem_rdata;
                        end else begin
                            dma_rdata_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes, grant and acks decode straight from state so reset kills them at once.
    always_comb begin
        mem_rd  = (state_q == ACCESS) && !wr_q;
        mem_wr  = (state_q == ACCESS) && wr_q;
        grant   = 2'b00;
        if (state_q != IDLE) begin
            grant = (owner_q == DMA) ? 2'b10 : 2'b01;
        end
        cpu_ack = (state_q == DONE) && (owner_q == CPU);
        dma_ack = (state_q == DONE) && (owner_q == DMA);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= CPU;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int WS = 1;

    logic          clk;
    logic          rst;
    logic          cpu_req, cpu_wr, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_wr, dma_ack;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    grant;

    logic          z_cpu_req, z_cpu_wr, z_cpu_ack;
    logic [AW-1:0] z_cpu_addr;
    logic [DW-1:0] z_cpu_wdata, z_cpu_rdata;
    logic          z_dma_req, z_dma_wr, z_dma_ack;
    logic [AW-1:0] z_dma_addr;
    logic [DW-1:0] z_dma_wdata, z_dma_rdata;
    logic          z_mem_rd, z_mem_wr;
    logic [AW-1:0] z_mem_addr;
    logic [DW-1:0] z_mem_wdata, z_mem_rdata;
    logic [1:0]    z_grant;

    logic [DW-1:0] tb_mem [16];

    int n_cmp;
    int n_fail;

    assign mem_rdata   = tb_mem[mem_addr[3:0]];
    assign z_mem_rdata = tb_mem[z_mem_addr[3:0]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst),
        .cpu_req(z_cpu_req), .cpu_wr(z_cpu_wr), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
        .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata),
        .dma_req(z_dma_req), .dma_wr(z_dma_wr), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata),
        .dma_ack(z_dma_ack), .dma_rdata(z_dma_rdata),
        .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .mem_rdata(z_mem_rdata), .grant(z_grant)
    );

    task automatic test_reset;
        rst = 1'b0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
        z_cpu_req = 0; z_cpu_wr = 0; z_cpu_addr = '0; z_cpu_wdata = '0;
        z_dma_req = 0; z_dma_wr = 0; z_dma_addr = '0; z_dma_wdata = '0;
        for (int i = 0; i < 16; i++) tb_mem[i] = $urandom;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({mem_rd, mem_wr, cpu_ack, dma_ack, grant} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000", {mem_rd, mem_wr, cpu_ack, dma_ack, grant});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        n_cmp++;
        if ({z_mem_rd, z_mem_wr, z_cpu_ack, z_dma_ack, z_grant, z_mem_addr, z_mem_wdata, z_cpu_rdata, z_dma_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_ws0: got nonzero outputs, want all 0");
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cpu_read;
        logic [5:0] exp;
        tb_mem[0] = 32'hDEADBEEF;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0040; cpu_wdata = $urandom;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            exp = {n <= 2, 1'b0, n == 3, 1'b0, (n <= 3) ? 2'b01 : 2'b00};
            n_cmp++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack, grant} !== exp) begin
                n_fail++;
                $display("FAIL cpu_read_ctrl c%0d: got %b want %b", n, {mem_rd, mem_wr, cpu_ack, dma_ack, grant}, exp);
            end
            if (n <= 2) begin
                n_cmp++;
                if (mem_addr !== 16'h0040) begin
                    n_fail++;
                    $display("FAIL cpu_read_addr c%0d: got %h want 0040", n, mem_addr);
                end
            end
            if (n == 3) begin
                n_cmp++;
                if (cpu_rdata !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL cpu_read_data: got %h want deadbeef", cpu_rdata);
                end
                cpu_req = 0;
            end
        end
    endtask

    task automatic test_dma_write;
        logic [5:0] exp;
        dma_req = 1; dma_wr = 1; dma_addr = 16'h0100; dma_wdata = 32'h12345678;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            exp = {1'b0, n <= 2, 1'b0, n == 3, (n <= 3) ? 2'b10 : 2'b00};
            n_cmp++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack, grant} !== exp) begin
                n_fail++;
                $display("FAIL dma_write_ctrl c%0d: got %b want %b", n, {mem_rd, mem_wr, cpu_ack, dma_ack, grant}, exp);
            end
            if (n <= 2) begin
                n_cmp++;
                if ({mem_addr, mem_wdata} !== {16'h0100, 32'h12345678}) begin
                    n_fail++;
                    $display("FAIL dma_write_bus c%0d: got %h/%h want 0100/12345678", n, mem_addr, mem_wdata);
                end
            end
            if (mem_wr) tb_mem[mem_addr[3:0]] = mem_wdata;
            if (n == 3) begin
                n_cmp++;
                if ({dma_rdata, cpu_rdata} !== {32'h0, 32'hDEADBEEF}) begin
                    n_fail++;
                    $display("FAIL dma_write_rdata_hold: got %h/%h want 0/deadbeef", dma_rdata, cpu_rdata);
                end
                dma_req = 0;
            end
        end
    endtask

    task automatic test_contention;
        logic [5:0]    exp;
        logic [DW-1:0] want [6];
        int            k, ph, own;
        for (int i = 2; i < 6; i++) begin
            tb_mem[i] = $urandom;
            want[i]   = tb_mem[i];
        end
        cpu_req = 1; cpu_wr = 0; cpu_addr = 16'd2;
        dma_req = 1; dma_wr = 0; dma_addr = 16'd3;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            k   = (n - 1) / 4;
            ph  = (n - 1) % 4 + 1;
            own = k % 2;
            exp = {ph <= 2, 1'b0, ph == 3 && own == 0, ph == 3 && own == 1,
                   (ph <= 3) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00};
            n_cmp++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack, grant} !== exp) begin
                n_fail++;
                $display("FAIL contention_ctrl c%0d: got %b want %b", n, {mem_rd, mem_wr, cpu_ack, dma_ack, grant}, exp);
            end
            if (ph <= 2) begin
                n_cmp++;
                if (mem_addr !== AW'(2 + k)) begin
                    n_fail++;
                    $display("FAIL contention_addr c%0d: got %h want %h", n, mem_addr, AW'(2 + k));
                end
            end
            if (ph == 3) begin
                n_cmp++;
                if (((own == 0) ? cpu_rdata : dma_rdata) !== want[2 + k]) begin
                    n_fail++;
                    $display("FAIL contention_rdata c%0d: got %h want %h", n, (own == 0) ? cpu_rdata : dma_rdata, want[2 + k]);
                end
                if (k == 0) cpu_addr = 16'd4;
                if (k == 1) dma_addr = 16'd5;
                if (k == 2) cpu_req = 0;
                if (k == 3) dma_req = 0;
            end
        end
    endtask

    task automatic test_ws0_back_to_back;
        logic [5:0] exp;
        int         k, ph;
        z_cpu_req = 1; z_cpu_wr = 0; z_cpu_addr = 16'd8;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            k   = (n - 1) / 3;
            ph  = n % 3;
            exp = {ph == 1, 1'b0, ph == 2, 1'b0, (ph != 0) ? 2'b01 : 2'b00};
            n_cmp++;
            if ({z_mem_rd, z_mem_wr, z_cpu_ack, z_dma_ack, z_grant} !== exp) begin
                n_fail++;
                $display("FAIL ws0_ctrl c%0d: got %b want %b", n, {z_mem_rd, z_mem_wr, z_cpu_ack, z_dma_ack, z_grant}, exp);
            end
            if (ph == 1) begin
                n_cmp++;
                if (z_mem_addr !== AW'(8 + k)) begin
                    n_fail++;
                    $display("FAIL ws0_addr c%0d: got %h want %h", n, z_mem_addr, AW'(8 + k));
                end
            end
            if (ph == 2) begin
                n_cmp++;
                if (z_cpu_rdata !== tb_mem[8 + k]) begin
                    n_fail++;
                    $display("FAIL ws0_rdata c%0d: got %h want %h", n, z_cpu_rdata, tb_mem[8 + k]);
                end
                z_cpu_req = 0;
            end
            if (ph == 0 && n < 9) begin
                z_cpu_req  = 1;
                z_cpu_addr = AW'(9 + k);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        logic [5:0] exp;
        dma_req = 1; dma_wr = 0; dma_addr = 16'd6;
        @(negedge clk);
        n_cmp++;
        if ({mem_rd, grant} !== 3'b110) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got %b want 110", {mem_rd, grant});
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_rd, mem_wr, dma_ack, grant, dma_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got rd=%b wr=%b ack=%b grant=%b rdata=%h want all 0", mem_rd, mem_wr, dma_ack, grant, dma_rdata);
        end
        dma_req = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack, grant} !== 6'b0) begin
                n_fail++;
                $display("FAIL rst_mid_no_ack c%0d: got %b want 000000", n, {mem_rd, mem_wr, cpu_ack, dma_ack, grant});
            end
        end
        cpu_req = 1; cpu_wr = 0; cpu_addr = 16'd7;
        dma_req = 1; dma_wr = 0; dma_addr = 16'd6;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            exp = {n <= 2, 1'b0, n == 3, 1'b0, (n <= 3) ? 2'b01 : 2'b00};
            n_cmp++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack, grant} !== exp) begin
                n_fail++;
                $display("FAIL rst_mid_cpu_first c%0d: got %b want %b", n, {mem_rd, mem_wr, cpu_ack, dma_ack, grant}, exp);
            end
            if (n == 3) begin
                n_cmp++;
                if (cpu_rdata !== tb_mem[7]) begin
                    n_fail++;
                    $display("FAIL rst_mid_cpu_rdata: got %h want %h", cpu_rdata, tb_mem[7]);
                end
                cpu_req = 0;
                dma_req = 0;
            end
        end
    endtask

    task automatic test_random;
        int            n_cyc;
        logic [DW-1:0] ref_mem [16];
        logic          rq [2];
        logic          wrv [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        logic          busy [2];
        logic [DW-1:0] exp_rdata [2];
        int            free, tx_start, tx_own, last;
        bit            tx_valid, in_acc, in_done;
        logic          tx_wr;
        logic [AW-1:0] tx_addr;
        logic [DW-1:0] tx_wdata;
        logic [5:0]    exp;
        n_cyc = 800;
        cpu_req = 0; dma_req = 0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        for (int m = 0; m < 2; m++) begin
            rq[m] = 0; wrv[m] = 0; ad[m] = '0; wd[m] = '0; busy[m] = 0; exp_rdata[m] = '0;
        end
        free = 0; tx_start = 0; tx_own = 0; last = 1; tx_valid = 0;
        tx_wr = 0; tx_addr = '0; tx_wdata = '0;
        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            in_acc  = tx_valid && cyc >= tx_start + 1 && cyc <= tx_start + WS + 1;
            in_done = tx_valid && cyc == tx_start + WS + 2;
            if (in_done) begin
                if (tx_wr) ref_mem[tx_addr[3:0]] = tx_wdata;
                else       exp_rdata[tx_own]    = ref_mem[tx_addr[3:0]];
            end
            exp = {in_acc && !tx_wr, in_acc && tx_wr, in_done && tx_own == 0, in_done && tx_own == 1,
                   (in_acc || in_done) ? ((tx_own == 1) ? 2'b10 : 2'b01) : 2'b00};
            n_cmp++;
            if ({mem_rd, mem_wr, cpu_ack, dma_ack, grant} !== exp) begin
                n_fail++;
                $display("FAIL rand_ctrl c%0d: got %b want %b", cyc, {mem_rd, mem_wr, cpu_ack, dma_ack, grant}, exp);
            end
            if (in_acc) begin
                n_cmp++;
                if ({mem_addr, mem_wdata} !== {tx_addr, tx_wdata}) begin
                    n_fail++;
                    $display("FAIL rand_bus c%0d: got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, tx_addr, tx_wdata);
                end
            end
            n_cmp++;
            if ({cpu_rdata, dma_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
                n_fail++;
                $display("FAIL rand_rdata c%0d: got %h/%h want %h/%h", cyc, cpu_rdata, dma_rdata, exp_rdata[0], exp_rdata[1]);
            end
            if (mem_wr) tb_mem[mem_addr[3:0]] = mem_wdata;
            for (int m = 0; m < 2; m++) begin
                if (in_done && tx_own == m) busy[m] = 0;
                if (busy[m] && in_acc && tx_own == m && $urandom_range(7) == 0) begin
                    rq[m] = 0; wrv[m] = 1'($urandom); ad[m] = AW'($urandom); wd[m] = $urandom;
                end else if (!busy[m]) begin
                    if (cyc < n_cyc - 20 && $urandom_range(2) == 0) begin
                        busy[m] = 1; rq[m] = 1;
                        wrv[m] = 1'($urandom); ad[m] = AW'($urandom); wd[m] = $urandom;
                    end else begin
                        rq[m] = 0;
                    end
                end
            end
            cpu_req = rq[0]; cpu_wr = wrv[0]; cpu_addr = ad[0]; cpu_wdata = wd[0];
            dma_req = rq[1]; dma_wr = wrv[1]; dma_addr = ad[1]; dma_wdata = wd[1];
            if (cyc >= free && (rq[0] || rq[1])) begin
                if (rq[0] && rq[1]) tx_own = (last == 0) ? 1 : 0;
                else                tx_own = rq[1] ? 1 : 0;
                tx_wr    = wrv[tx_own];
                tx_addr  = ad[tx_own];
                tx_wdata = wd[tx_own];
                tx_start = cyc;
                tx_valid = 1;
                free     = cyc + WS + 3;
                last     = tx_own;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset;
        test_cpu_read;
        test_dma_write;
        test_contention;
        test_ws0_back_to_back;
        test_reset_mid_access;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
